// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared widths, request payload type and round-robin pick function
package bram_arb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_MAX = 32;
    localparam int REQ_MAX = 8;

    // Address is carried at its widest; the top slices it down to its own ADDR_WIDTH.
    typedef struct packed {
        logic [ADDR_MAX-1:0]   addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } bram_req_t;

    // First valid index after ptr, wrapping at n. Scanning from the far end down lets
    // the nearest candidate overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [REQ_MAX-1:0] valid, input logic [2:0] ptr, input int n);
        logic [2:0] w;
        int idx;
        w = ptr;
        for (int i = REQ_MAX; i >= 1; i--) begin
            if (i <= n) begin
                idx = (int'(ptr) + i) % n;
                if (valid[idx]) w = 3'(idx);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bram_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant among N valids; round-robin, or fixed priority under BRAM_ARB_FIXED_PRIO_EN
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
    // Lowest set bit wins; no state is kept.
    always_comb grant = valid & (~valid + N'(1));
`else
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [2:0]    win;

    // Winner is the first valid after the last granted requester.
    always_comb begin
        win = rr_pick(REQ_MAX'(valid), 3'(ptr), N);
        grant = (|valid) ? N'(1) << win : '0;
    end

    // Pointer moves to the winner only when the grant is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) ptr <= IW'(N - 1);
        else if (advance) ptr <= win[IW-1:0];
    end
`endif

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port bram among NUM_REQ requesters (BRAM_ARB_FIXED_PRIO_EN selects fixed priority)
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int MEM_DEPTH  = 1024 * 1024,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                               MCLK,
    input  logic                               MRESETn,
    input  logic [NUM_REQ-1:0]                 REQ_VALID,
    output logic [NUM_REQ-1:0]                 REQ_READY,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      REQ_WDATA,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]      REQ_WSTRB,
    output logic [NUM_REQ-1:0]                 RSP_VALID,
    output logic [DATA_WIDTH-1:0]              RSP_RDATA,
    output logic                               MEN,
    output logic [ADDR_WIDTH-1:0]              MADDR,
    output logic [DATA_WIDTH-1:0]              MDIN,
    output logic [STRB_WIDTH-1:0]              MWE,
    input  logic [DATA_WIDTH-1:0]              MDOUT
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic               hs;
    bram_req_t          sel;
    logic [ID_W-1:0]    id;
    logic [ID_W-1:0]    id_s1, id_s2;
    logic               rd_s1, rd_s2, v_s2;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (MCLK),
        .rst_n   (MRESETn),
        .valid   (REQ_VALID),
        .advance (hs),
        .grant   (grant)
    );

    assign REQ_READY = MRESETn ? grant : '0;
    assign hs = |REQ_READY;

    // Payload mux; with no grant it yields all zeros, so MWE drops to 0 on idle cycles.
    always_comb begin
        sel = '0;
        id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.addr = ADDR_MAX'(REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]);
                sel.wdata = REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel.wstrb = REQ_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
                id = ID_W'(i);
            end
        end
    end

    // Issue register drives the bram; MEN doubles as the stage-1 valid.
    always_ff @(posedge MCLK) begin
        if (!MRESETn) begin
            MEN <= 1'b0;
            MADDR <= '0;
            MDIN <= '0;
            MWE <= '0;
            id_s1 <= '0;
            rd_s1 <= 1'b0;
            v_s2 <= 1'b0;
            id_s2 <= '0;
            rd_s2 <= 1'b0;
        end else begin
            MEN <= hs;
            MADDR <= sel.addr[ADDR_WIDTH-1:0];
            MDIN <= sel.wdata;
            MWE <= sel.wstrb;
            id_s1 <= id;
            rd_s1 <= sel.wstrb == '0;
            v_s2 <= MEN;
            id_s2 <= id_s1;
            rd_s2 <= rd_s1;
        end
    end

    // Held low during reset so an op already in the response stage is dropped too.
    assign RSP_VALID = (v_s2 && MRESETn) ? NUM_REQ'(1) << id_s2 : '0;
    assign RSP_RDATA = (v_s2 && rd_s2 && MRESETn) ? MDOUT : '0;

endmodule
